// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - shared prescaler with programmable divide channels and a valid/ready config port
module divider_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CW     = 32,
    parameter int PRE    = 100000,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pause,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CW-1:0]     cfg_upto,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_clk
);

    localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [PW-1:0]  LP_PRE_LAST = PW'(PRE - 1);
    localparam logic [CHW:0]   LP_NCH      = (CHW + 1)'(NUM_CH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_err;
    logic [CHW-1:0]      r_ch;
    logic [CW-1:0]       r_new_upto;
    logic                r_new_en;

    logic [PW-1:0]       r_pre;
    logic [CW-1:0]       r_cnt  [NUM_CH];
    logic [CW-1:0]       r_upto [NUM_CH];
    logic [NUM_CH-1:0]   r_en;
    logic [NUM_CH-1:0]   r_tick;
    logic [NUM_CH-1:0]   r_div;

    logic                w_base_tick;
    logic                w_ch_ok_in;
    logic [NUM_CH-1:0]   w_apply_hit;

    assign w_base_tick = !pause && (r_pre == LP_PRE_LAST);
    assign w_ch_ok_in  = ({1'b0, cfg_ch} < LP_NCH);

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = r_tick;
    assign div_clk   = r_div;

    // Free-running prescaler; frozen while paused, wraps on the base tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_base_tick) begin
            r_pre <= '0;
        end else if (!pause) begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Config handshake: accept in IDLE, write the channel in APPLY; cfg_err is high during APPLY of a bad channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_ch       <= '0;
            r_new_upto <= '0;
            r_new_en   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_err   <= 1'b0;
                    if (cfg_valid && r_ready) begin
                        r_state    <= S_APPLY;
                        r_ready    <= 1'b0;
                        r_ch       <= cfg_ch;
                        r_new_upto <= cfg_upto;
                        r_new_en   <= cfg_en;
                        r_err      <= !w_ch_ok_in;
                    end
                end
                S_APPLY: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Decode which channel (if any) is being written this cycle; an out-of-range index matches none.
    always_comb begin
        w_apply_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((r_state == S_APPLY) && (r_ch == CHW'(i))) begin
                w_apply_hit[i] = 1'b1;
            end
        end
    end

    // Per-channel divide counters; a config write takes priority over a coincident base tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]  <= '0;
                r_upto[i] <= '0;
            end
            r_en   <= '0;
            r_tick <= '0;
            r_div  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tick[i] <= 1'b0;
                if (w_apply_hit[i]) begin
                    r_upto[i] <= r_new_upto;
                    r_en[i]   <= r_new_en;
                    r_cnt[i]  <= '0;
                    if (!r_new_en) begin
                        r_div[i] <= 1'b0;
                    end
                end else if (!r_en[i]) begin
                    r_cnt[i] <= '0;
                    r_div[i] <= 1'b0;
                end else if (w_base_tick) begin
                    if (r_cnt[i] == r_upto[i]) begin
                        r_cnt[i]  <= '0;
                        r_div[i]  <= ~r_div[i];
                        r_tick[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_scheduler.sv
// tb/tb_divider_scheduler.sv - directed self-checking bench for divider_scheduler
module tb_divider_scheduler;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int PRE = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           pause = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_en = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_upto = '0;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] div_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_cnt [NCH] = '{0, 0, 0};

    divider_scheduler #(
        .NUM_CH (NCH),
        .CW     (CW),
        .PRE    (PRE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause     (pause),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_upto  (cfg_upto),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .div_clk   (div_clk)
    );

    always #5 clk = ~clk;

    // Edge counter used as the time reference for expected tick positions.
    always @(posedge clk) cyc <= cyc + 1;

    // Running tick count per channel; its parity is the expected div_clk level while a channel stays enabled.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (tick[i] === 1'b1) tick_cnt[i] = tick_cnt[i] + 1;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int ch, input int maxc, output int at);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick[ch] !== 1'b1 && n < maxc);
        at = cyc;
        chk($sformatf("tick%0d_seen", ch), 32'(tick[ch]), 32'd1);
    endtask

    task automatic do_cfg(input int ch, input int upto, input logic en);
        int n;
        n = 0;
        cfg_ch    = 2'(ch);
        cfg_upto  = CW'(upto);
        cfg_en    = en;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        int t0, t, a, b, cnt;

        // Reset held for three edges
        step(); step(); step();
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_div", 32'(div_clk), 0);
        chk("rst_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        step();
        chk("ready_first_edge", 32'(cfg_ready), 1);
        t0 = cyc;

        // ch0 upto=2: tick every 12 clocks, first base tick lands on the 4th edge after release
        cfg_ch = 2'd0; cfg_upto = 8'd2; cfg_en = 1'b1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("apply_ready_low", 32'(cfg_ready), 0);
        chk("apply_err_good_ch", 32'(cfg_err), 0);
        step();
        chk("ready_after_apply", 32'(cfg_ready), 1);
        wait_tick(0, 40, t);
        chk("ch0_first_tick_pos", t, t0 + 11);
        chk("ch0_div_after_1", 32'(div_clk[0]), 1);
        step();
        chk("ch0_tick_one_cycle", 32'(tick[0]), 0);
        wait_tick(0, 40, a);
        chk("ch0_period", a - t, 12);
        chk("ch0_div_after_2", 32'(div_clk[0]), 0);

        // ch1 upto=0: toggles every base tick (4 clocks)
        do_cfg(1, 0, 1'b1);
        wait_tick(1, 20, t);
        chk("ch1_first_tick_pos", t, a + 4);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick[1] === 1'b1) cnt++;
        end
        chk("ch1_ticks_in_16", cnt, 4);
        chk("ch1_div_parity", 32'(div_clk[1]), tick_cnt[1] % 2);
        wait_tick(1, 20, a);
        chk("ch1_period", a - (t + 16), 4);

        // ch2 upto=0 as a reference channel
        do_cfg(2, 0, 1'b1);

        // Reconfigure ch0 at counter=1 to upto=5
        wait_tick(0, 40, t);
        for (int k = 0; k < 4; k++) step();
        do_cfg(0, 5, 1'b1);
        chk("ch0_div_kept", 32'(div_clk[0]), tick_cnt[0] % 2);
        wait_tick(0, 60, a);
        chk("ch0_reconf_tick_pos", a, t + 28);
        wait_tick(0, 60, b);
        chk("ch0_new_period", b - a, 24);

        // Config landing exactly on a base-tick edge for ch1
        wait_tick(1, 20, b);
        step(); step();
        do_cfg(1, 0, 1'b1);
        chk("collide_ch1_no_tick", 32'(tick[1]), 0);
        chk("collide_ch2_ticks", 32'(tick[2]), 1);
        chk("collide_ch1_div_kept", 32'(div_clk[1]), tick_cnt[1] % 2);
        wait_tick(1, 20, t);
        chk("collide_ch1_next", t, b + 8);

        // Disable ch1 while its div_clk is high
        for (int k = 0; k < 3 && (tick_cnt[1] % 2) == 0; k++) wait_tick(1, 20, t);
        chk("ch1_div_high_pre_dis", 32'(div_clk[1]), 1);
        do_cfg(1, 0, 1'b0);
        chk("ch1_div_cleared", 32'(div_clk[1]), 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick[1] !== 1'b0 || div_clk[1] !== 1'b0) cnt++;
        end
        chk("ch1_quiet_disabled", cnt, 0);

        // Pause for 10 clocks right after a ch2 tick, with a config issued while paused
        wait_tick(2, 20, t);
        pause = 1'b1;
        cfg_ch = 2'd1; cfg_upto = 8'd7; cfg_en = 1'b0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("pause_cfg_accepted", 32'(cfg_ready), 0);
        step();
        chk("pause_cfg_ready_back", 32'(cfg_ready), 1);
        while (cyc < t + 10) step();
        pause = 1'b0;
        wait_tick(2, 30, a);
        chk("pause_delay", a, t + 14);

        // Out-of-range channel
        cfg_ch = 2'd3; cfg_upto = 8'd1; cfg_en = 1'b1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("bad_ch_err_pulse", 32'(cfg_err), 1);
        chk("bad_ch_ready_low", 32'(cfg_ready), 0);
        step();
        chk("bad_ch_err_clear", 32'(cfg_err), 0);
        chk("bad_ch_ready_back", 32'(cfg_ready), 1);
        wait_tick(2, 20, t);
        wait_tick(2, 20, a);
        chk("bad_ch_ch2_period", a - t, 4);
        chk("bad_ch_ch0_div", 32'(div_clk[0]), tick_cnt[0] % 2);

        // Reset asserted during APPLY
        cfg_ch = 2'd2; cfg_upto = 8'd0; cfg_en = 1'b0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("rst_apply_in_apply", 32'(cfg_ready), 0);
        rst_n = 1'b0;
        step();
        chk("rst_apply_tick", 32'(tick), 0);
        chk("rst_apply_div", 32'(div_clk), 0);
        chk("rst_apply_ready", 32'(cfg_ready), 0);
        chk("rst_apply_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        step();
        chk("rst_apply_ready_back", 32'(cfg_ready), 1);
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (tick !== 3'b000 || div_clk !== 3'b000) cnt++;
        end
        chk("post_reset_all_quiet", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
